// File: rtl/huffman_pkg.sv
// huffman_pkg: shared types and constants for the JPEG entropy-stream byte packer.
//   PackerState_e : packer FSM states
//   MARKER_FF, STUFF_BYTE, EOI_LO : marker / stuffing byte values
//   PackedByte_t  : one output byte plus its end-of-frame flag
//   clamp_len     : limits an incoming code length to 32 bits
package huffman_pkg;

  typedef enum logic [2:0] {
    StRun,
    StStuff,
    StPad,
    StStuffPad,
    StEoiFf,
    StEoiD9,
    StDoneEop
  } PackerState_e;

  localparam logic [7:0] MARKER_FF  = 8'hFF;
  localparam logic [7:0] STUFF_BYTE = 8'h00;
  localparam logic [7:0] EOI_LO     = 8'hD9;

  typedef struct packed {
    logic [7:0] data;
    logic       eop;
  } PackedByte_t;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    return (len > 6'd32) ? 6'd32 : len;
  endfunction

endpackage

// File: rtl/jpeg_bit_accum.sv
// jpeg_bit_accum: left-aligned bit accumulator for the byte packer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_ins       : append i_len low bits of i_code after the valid bits
//   i_code      : code bits, right-aligned
//   i_len       : number of bits to append, 0..32 (already clamped)
//   i_shift     : drop the top byte (acc <<= 8, cnt -= 8) before any append
//   i_clear     : discard everything (used after the final partial byte)
//   o_top       : top 8 bits of the accumulator
//   o_cnt       : number of valid bits held
module jpeg_bit_accum
  import huffman_pkg::*;
#(
  parameter int unsigned ACC_W = 64,  // must be >= 64
  localparam int unsigned CNT_W = $clog2(ACC_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ins,
  input  logic [31:0]      i_code,
  input  logic [5:0]       i_len,
  input  logic             i_shift,
  input  logic             i_clear,
  output logic [7:0]       o_top,
  output logic [CNT_W-1:0] o_cnt
);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0]      w_mask;
  logic [31:0]      w_left;
  logic [ACC_W-1:0] w_acc_s;
  logic [ACC_W-1:0] w_ins;
  logic [CNT_W-1:0] w_cnt_s;

  always_comb begin
    w_mask  = (i_len >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << i_len) - 32'd1);
    // Move the masked code to the MSB end; len=0 shifts everything out.
    w_left  = (i_code & w_mask) << (6'd32 - i_len);
    w_acc_s = i_shift ? (r_acc << 8) : r_acc;
    w_cnt_s = i_shift ? (r_cnt - CNT_W'(8)) : r_cnt;
    // New bits land immediately below the bits still held after any shift-out.
    w_ins   = {w_left, {(ACC_W - 32){1'b0}}} >> w_cnt_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      r_acc <= i_ins ? (w_acc_s | w_ins) : w_acc_s;
      r_cnt <= i_ins ? (w_cnt_s + CNT_W'(i_len)) : w_cnt_s;
    end
  end

  assign o_top = r_acc[ACC_W-1 -: 8];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/jpeg_byte_packer.sv
// jpeg_byte_packer: packs variable-length code words into the JPEG entropy-coded
// byte stream with 0xFF->0xFF00 stuffing, 1-padding at end of frame and an
// optional EOI marker.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready             : code word handshake
//   in_code, in_len, in_eop       : right-aligned code, bit count 0..32, last word
//   out_valid/out_ready           : byte handshake
//   out_data, out_eop             : packed byte, last byte of frame
module jpeg_byte_packer
  import huffman_pkg::*;
#(
  parameter bit          EMIT_EOI = 1'b1,
  parameter int unsigned ACC_W    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_code,
  input  logic [5:0]  in_len,
  input  logic        in_eop,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_eop,
  input  logic        out_ready
);

  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] CntByte  = CNT_W'(8);
  localparam logic [CNT_W-1:0] CntInMax = CNT_W'(ACC_W - 32);

  PackerState_e r_state, w_state_d;
  PackedByte_t  r_out, w_byte;
  logic         r_out_valid;
  logic         r_eop_pend, w_eop_pend_d;
  logic         r_rdy_en;

  logic [7:0]       w_top;
  logic [7:0]       w_pad_byte;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_cnt_after;
  logic [5:0]       w_len;
  logic             w_accept;
  logic             w_load;
  logic             w_emit;
  logic             w_shift;
  logic             w_clear;
  logic             w_eop_now;

  assign w_len = clamp_len(in_len);

  // r_rdy_en keeps in_ready low while in reset. The last-byte term holds off the
  // next frame until the flagged byte has actually been taken.
  assign in_ready = r_rdy_en && (r_state == StRun) && !r_eop_pend &&
                    !(r_out_valid && r_out.eop) && (w_cnt <= CntInMax);
  assign w_accept = in_valid && in_ready;
  assign w_load   = !r_out_valid || out_ready;

  // Only called in StPad where cnt < 8; bits below cnt are already zero.
  assign w_pad_byte  = w_top | (8'hFF >> w_cnt[2:0]);
  assign w_eop_now   = r_eop_pend || (w_accept && in_eop);
  assign w_cnt_after = w_cnt - CntByte + (w_accept ? CNT_W'(w_len) : '0);

  jpeg_bit_accum #(
    .ACC_W (ACC_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_ins   (w_accept),
    .i_code  (in_code),
    .i_len   (w_len),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .o_top   (w_top),
    .o_cnt   (w_cnt)
  );

  always_comb begin
    w_state_d    = r_state;
    w_eop_pend_d = r_eop_pend || (w_accept && in_eop);
    w_emit       = 1'b0;
    w_byte       = '0;
    w_shift      = 1'b0;
    w_clear      = 1'b0;

    unique case (r_state)
      StRun: begin
        if (w_load && (w_cnt >= CntByte)) begin
          w_emit      = 1'b1;
          w_byte.data = w_top;
          w_shift     = 1'b1;
          if (w_top == MARKER_FF) begin
            w_state_d = StStuff;
          end else if (!EMIT_EOI && w_eop_now && (w_cnt_after == '0)) begin
            // Without EOI the last data byte itself carries the frame end.
            w_byte.eop = 1'b1;
            w_state_d  = StDoneEop;
          end
        end else if (r_eop_pend && (w_cnt < CntByte)) begin
          w_state_d = StPad;
        end
      end

      StStuff: begin
        if (w_load) begin
          w_emit      = 1'b1;
          w_byte.data = STUFF_BYTE;
          if (!EMIT_EOI && r_eop_pend && (w_cnt == '0)) begin
            w_byte.eop = 1'b1;
            w_state_d  = StDoneEop;
          end else begin
            w_state_d = StRun;
          end
        end
      end

      StPad: begin
        if (w_cnt == '0) begin
          w_state_d = EMIT_EOI ? StEoiFf : StDoneEop;
        end else if (w_load) begin
          w_emit      = 1'b1;
          w_byte.data = w_pad_byte;
          w_clear     = 1'b1;
          if (w_pad_byte == MARKER_FF) begin
            w_state_d = StStuffPad;
          end else if (EMIT_EOI) begin
            w_state_d = StEoiFf;
          end else begin
            w_byte.eop = 1'b1;
            w_state_d  = StDoneEop;
          end
        end
      end

      StStuffPad: begin
        if (w_load) begin
          w_emit      = 1'b1;
          w_byte.data = STUFF_BYTE;
          w_byte.eop  = !EMIT_EOI;
          w_state_d   = EMIT_EOI ? StEoiFf : StDoneEop;
        end
      end

      StEoiFf: begin
        if (w_load) begin
          w_emit      = 1'b1;
          w_byte.data = MARKER_FF;
          w_state_d   = StEoiD9;
        end
      end

      StEoiD9: begin
        if (w_load) begin
          w_emit       = 1'b1;
          w_byte.data  = EOI_LO;
          w_byte.eop   = 1'b1;
          w_eop_pend_d = 1'b0;
          w_state_d    = StRun;
        end
      end

      StDoneEop: begin
        w_eop_pend_d = 1'b0;
        w_state_d    = StRun;
      end

      default: begin
        w_state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_eop_pend  <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_state    <= w_state_d;
      r_eop_pend <= w_eop_pend_d;
      r_rdy_en   <= 1'b1;
      if (w_load) begin
        r_out_valid <= w_emit;
        if (w_emit) begin
          r_out <= w_byte;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out.data;
  assign out_eop   = r_out.eop;

  a_len_legal : assert property (@(posedge clk) disable iff (!rst_n)
                                 in_valid |-> (in_len <= 6'd32));

endmodule

// File: tb/tb_jpeg_byte_packer.sv
// tb_jpeg_byte_packer: directed self-checking bench for jpeg_byte_packer (EMIT_EOI=1).
module tb_jpeg_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_code = '0;
  logic [5:0]  in_len = '0;
  logic        in_eop = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_eop;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] got_q[$];  // {eop, data} of each handshaken byte
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  jpeg_byte_packer #(
    .EMIT_EOI (1'b1),
    .ACC_W    (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_len    (in_len),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_eop   (out_eop),
    .out_ready (out_ready)
  );

  // Handshakes sampled mid-cycle; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back({out_eop, out_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [31:0] code, input int len, input logic eop);
    int n = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_len   = 6'(len);
    in_eop   = eop;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_code  = '0;
    in_len   = '0;
    in_eop   = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int n = exp_q.size();
    int k = 0;
    while (got_q.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'h00);
    check_eq("rst_out_eop", 32'(out_eop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 101 + 11111 -> 0xBF, registered one cycle after the completing accept
    send(32'h5, 3, 1'b0);
    send(32'h1F, 5, 1'b0);
    check_eq("t1_valid_not_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t1_valid_latency", 32'(out_valid), 32'd1);
    check_eq("t1_data_latency", 32'(out_data), 32'hBF);
    exp_q.push_back({1'b0, 8'hBF});
    check_stream("t1");

    // 0xFF gets a stuffed 0x00; input stalls only during the stuff cycle
    send(32'hFF, 8, 1'b0);
    send(32'h12, 8, 1'b0);
    check_eq("t2_ready_stuff", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t2_ready_back", 32'(in_ready), 32'd1);
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h12});
    check_stream("t2");

    // 3 bits + eop: pad byte BF then EOI, eop only on D9
    send(32'h5, 3, 1'b1);
    check_eq("t3_ready_eop_pend", 32'(in_ready), 32'd0);
    exp_q.push_back({1'b0, 8'hBF});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b1, 8'hD9});
    check_stream("t3");
    check_eq("t3_ready_after_frame", 32'(in_ready), 32'd1);

    // 7 ones + eop: pad to FF, stuffed, then unstuffed EOI
    send(32'h7F, 7, 1'b1);
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b1, 8'hD9});
    check_stream("t4");

    // Masking of bits above in_len, and a zero-length word
    send(32'hFFFF_FFF5, 4, 1'b0);
    send(32'h0000_DEAD, 0, 1'b0);
    send(32'h0000_0003, 4, 1'b0);
    exp_q.push_back({1'b0, 8'h53});
    check_stream("t5");

    // Backpressure: 128 bits with the output stalled for 10 cycles
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'hAAAA_AAAA, 32, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_ready_full", 32'(in_ready), 32'd0);
        check_eq("t6_valid_stall", 32'(out_valid), 32'd1);
        check_eq("t6_data_stall_a", 32'(out_data), 32'hAA);
        repeat (7) @(posedge clk);
        #1;
        check_eq("t6_ready_still_full", 32'(in_ready), 32'd0);
        check_eq("t6_valid_held", 32'(out_valid), 32'd1);
        check_eq("t6_data_stall_b", 32'(out_data), 32'hAA);
        check_eq("t6_no_handshake", 32'(got_q.size()), 32'd0);
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'hAA});
    check_stream("t6");

    // Asynchronous reset mid-stream discards buffered bits
    out_ready = 1'b0;
    send(32'h0AAA_AAAA, 28, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t7_valid_before_rst", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("t7_rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    @(posedge clk);
    #1;
    send(32'h3C, 8, 1'b0);
    exp_q.push_back({1'b0, 8'h3C});
    check_stream("t7");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
